alu_branch_ctrl_pipe: RTL and testbench

Pipelined, parametrised ALU-control and branch-resolution stage that sits between instruction decode and execute. Decodes func3/func7/op5/ALUOp into an extended ALU control code and registers it (stage S1). Resolves all six RV32I branch conditions plus jumps from ALU flags, and registers PCSrc (stage S2). Squashes wrong-path instructions after a taken branch and keeps saturating branch statistics.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_ctrl_decode.sv | 39 +++
 rtl/alu_branch_ctrl_pipe.sv | 129 ++++++++++++
 tb/tb_alu_branch_ctrl_pipe.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the ALU-control / branch-resolution stage.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD     = 4'h0,
    ALU_SUB     = 4'h1,
    ALU_AND     = 4'h2,
    ALU_OR      = 4'h3,
    ALU_XOR     = 4'h4,
    ALU_SLT     = 4'h5,
    ALU_SLTU    = 4'h6,
    ALU_SLL     = 4'h7,
    ALU_SRL     = 4'h8,
    ALU_SRA     = 4'h9,
    ALU_ILLEGAL = 4'hF
  } alu_ctrl_e;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ILL   = 2'b11;

  localparam int FLUSH_MAX = 7;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational decode of func3/func7_5/op5/ALUOp into an ALU control code.
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [2:0] func3,
  input  logic       func7_5,
  input  logic       op5,
  input  logic [1:0] alu_op,
  output alu_ctrl_e  alu_ctrl,
  output logic       alu_illegal
);

  always_comb begin
    alu_ctrl    = ALU_ADD;
    alu_illegal = 1'b0;
    case (alu_op)
      ALUOP_ADD: alu_ctrl = ALU_ADD;
      ALUOP_SUB: alu_ctrl = ALU_SUB;
      ALUOP_RTYPE: begin
        case (func3)
          // immediate forms (op5=0) never subtract, even with func7_5 set
          3'b000:  alu_ctrl = (op5 & func7_5) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_ctrl = ALU_SLL;
          3'b010:  alu_ctrl = ALU_SLT;
          3'b011:  alu_ctrl = ALU_SLTU;
          3'b100:  alu_ctrl = ALU_XOR;
          3'b101:  alu_ctrl = func7_5 ? ALU_SRA : ALU_SRL;
          3'b110:  alu_ctrl = ALU_OR;
          default: alu_ctrl = ALU_AND;
        endcase
      end
      default: begin
        alu_ctrl    = ALU_ILLEGAL;
        alu_illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_branch_ctrl_pipe.sv
// Two-stage ALU-control / branch-resolution pipe with wrong-path squash and
// saturating branch statistics. CTRL_W must be at least 4.
module alu_branch_ctrl_pipe
  import alu_pkg::*;
#(
  parameter int CTRL_W      = 4,
  parameter int CNT_W       = 16,
  parameter int FLUSH_DEPTH = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        func3,
  input  logic              func7_5,
  input  logic              op5,
  input  logic [1:0]        alu_op,
  input  logic              branch,
  input  logic              jump,
  input  logic              flag_zero,
  input  logic              flag_lt,
  input  logic              flag_ltu,
  input  logic              ex_ready,
  input  logic              clear_cnt,
  output logic              ctrl_valid,
  output logic [CTRL_W-1:0] alu_ctrl_o,
  output logic              illegal_o,
  output logic              pcsrc_o,
  output logic              res_valid,
  output logic              flush_o,
  output logic [CNT_W-1:0]  branch_cnt_o,
  output logic [CNT_W-1:0]  taken_cnt_o
);

  localparam int              FLUSH_LD = (FLUSH_DEPTH > FLUSH_MAX) ? FLUSH_MAX : FLUSH_DEPTH;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  alu_ctrl_e  dec_ctrl;
  logic       dec_illegal;
  logic       br_illegal;
  logic       s1_branch, s1_jump;
  logic [2:0] s1_func3;
  logic [2:0] sq_cnt;
  logic       cond_met, xfer, taken_xfer, hs, load, resolves;

  alu_ctrl_decode u_decode (
    .func3       (func3),
    .func7_5     (func7_5),
    .op5         (op5),
    .alu_op      (alu_op),
    .alu_ctrl    (dec_ctrl),
    .alu_illegal (dec_illegal)
  );

  assign br_illegal = branch & ((func3 == 3'b010) | (func3 == 3'b011));

  always_comb begin
    cond_met = 1'b0;
    case (s1_func3)
      F3_BEQ:  cond_met = flag_zero;
      F3_BNE:  cond_met = ~flag_zero;
      F3_BLT:  cond_met = flag_lt;
      F3_BGE:  cond_met = ~flag_lt;
      F3_BLTU: cond_met = flag_ltu;
      F3_BGEU: cond_met = ~flag_ltu;
      default: cond_met = 1'b0;
    endcase
  end

  assign in_ready   = ~ctrl_valid | ex_ready;
  assign xfer       = ctrl_valid & ex_ready;
  assign taken_xfer = xfer & (s1_jump | (s1_branch & cond_met));
  assign flush_o    = taken_xfer | (sq_cnt != 3'd0);
  assign hs         = in_valid & in_ready;
  assign load       = hs & ~flush_o;
  assign resolves   = xfer & (s1_branch | s1_jump);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_valid <= 1'b0;
      alu_ctrl_o <= '0;
      illegal_o  <= 1'b0;
      s1_branch  <= 1'b0;
      s1_jump    <= 1'b0;
      s1_func3   <= 3'd0;
    end else if (load) begin
      ctrl_valid <= 1'b1;
      alu_ctrl_o <= CTRL_W'(dec_ctrl);
      illegal_o  <= dec_illegal | br_illegal;
      s1_branch  <= branch;
      s1_jump    <= jump;
      s1_func3   <= func3;
    end else if (xfer) begin
      ctrl_valid <= 1'b0;
    end
  end

  // the same-cycle handshake is squashed by taken_xfer itself, so the reload ignores it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sq_cnt    <= 3'd0;
      res_valid <= 1'b0;
      pcsrc_o   <= 1'b0;
    end else begin
      res_valid <= xfer;
      pcsrc_o   <= taken_xfer;
      if (taken_xfer)
        sq_cnt <= 3'(FLUSH_LD);
      else if (hs && sq_cnt != 3'd0)
        sq_cnt <= sq_cnt - 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt_o <= '0;
      taken_cnt_o  <= '0;
    end else if (clear_cnt) begin
      branch_cnt_o <= '0;
      taken_cnt_o  <= '0;
    end else begin
      if (resolves && branch_cnt_o != CNT_MAX)
        branch_cnt_o <= branch_cnt_o + 1'b1;
      if (taken_xfer && taken_cnt_o != CNT_MAX)
        taken_cnt_o <= taken_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_branch_ctrl_pipe.sv
// Randomized and directed bench for alu_branch_ctrl_pipe against a
// transaction-level model of the decode, branch and squash rules.
module tb_alu_branch_ctrl_pipe;
  localparam int CTRL_W      = 5;
  localparam int CNT_W       = 2;
  localparam int FLUSH_DEPTH = 1;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0, in_ready;
  logic [2:0]        func3 = 3'd0;
  logic              func7_5 = 1'b0, op5 = 1'b0;
  logic [1:0]        alu_op = 2'd0;
  logic              branch = 1'b0, jump = 1'b0;
  logic              flag_zero = 1'b0, flag_lt = 1'b0, flag_ltu = 1'b0;
  logic              ex_ready = 1'b1, clear_cnt = 1'b0;
  logic              ctrl_valid, illegal_o, pcsrc_o, res_valid, flush_o;
  logic [CTRL_W-1:0] alu_ctrl_o;
  logic [CNT_W-1:0]  branch_cnt_o, taken_cnt_o;

  always #5 clk = ~clk;

  alu_branch_ctrl_pipe #(.CTRL_W(CTRL_W), .CNT_W(CNT_W), .FLUSH_DEPTH(FLUSH_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .func3(func3), .func7_5(func7_5), .op5(op5), .alu_op(alu_op),
    .branch(branch), .jump(jump), .flag_zero(flag_zero), .flag_lt(flag_lt),
    .flag_ltu(flag_ltu), .ex_ready(ex_ready), .clear_cnt(clear_cnt),
    .ctrl_valid(ctrl_valid), .alu_ctrl_o(alu_ctrl_o), .illegal_o(illegal_o),
    .pcsrc_o(pcsrc_o), .res_valid(res_valid), .flush_o(flush_o),
    .branch_cnt_o(branch_cnt_o), .taken_cnt_o(taken_cnt_o)
  );

  int n_chk = 0, n_err = 0;

  typedef struct {
    logic [3:0] code;
    bit         ill;
    bit         br;
    bit         jp;
    logic [2:0] f3;
  } entry_t;

  entry_t m_e;
  bit     m_valid, m_res, m_pc;
  int     m_sq, m_bcnt, m_tcnt;
  bit     obs_flush, obs_ready;
  logic [3:0] rtype_tab [8];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] ref_code(logic [1:0] aop, logic [2:0] f3, bit f75, bit o5);
    logic [3:0] r;
    if (aop == 2'b00)      r = 4'h0;
    else if (aop == 2'b01) r = 4'h1;
    else if (aop == 2'b11) r = 4'hF;
    else begin
      r = rtype_tab[f3];
      if (f3 == 3'd0 && o5 && f75) r = 4'h1;
      if (f3 == 3'd5 && f75)       r = 4'h9;
    end
    return r;
  endfunction

  function automatic bit ref_cond(logic [2:0] f3, bit z, bit lt, bit ltu);
    case (f3)
      3'd0: return z;
      3'd1: return !z;
      3'd4: return lt;
      3'd5: return !lt;
      3'd6: return ltu;
      3'd7: return !ltu;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_valid = 0; m_res = 0; m_pc = 0; m_sq = 0; m_bcnt = 0; m_tcnt = 0;
    m_e = '{code: 4'h0, ill: 1'b0, br: 1'b0, jp: 1'b0, f3: 3'd0};
  endtask

  task automatic set_in(bit v, logic [2:0] f3, bit f75, bit o5, logic [1:0] aop, bit br, bit jp);
    in_valid = v; func3 = f3; func7_5 = f75; op5 = o5; alu_op = aop; branch = br; jump = jp;
  endtask

  // Called just after a falling edge: checks this cycle, advances the model, waits one clock.
  task automatic cycle();
    bit exp_ready, xfer, taken, exp_flush, hs;
    #1;
    exp_ready = !m_valid || ex_ready;
    xfer      = m_valid && ex_ready;
    taken     = xfer && (m_e.jp || (m_e.br && ref_cond(m_e.f3, flag_zero, flag_lt, flag_ltu)));
    exp_flush = taken || (m_sq != 0);
    hs        = in_valid && exp_ready;
    obs_flush = flush_o;
    obs_ready = in_ready;
    chk("in_ready", in_ready, exp_ready);
    chk("flush_o", flush_o, exp_flush);
    chk("ctrl_valid", ctrl_valid, m_valid);
    if (m_valid) begin
      chk("alu_ctrl_o", alu_ctrl_o, m_e.code);
      chk("illegal_o", illegal_o, m_e.ill);
    end
    chk("res_valid", res_valid, m_res);
    chk("pcsrc_o", pcsrc_o, m_pc);
    chk("branch_cnt", branch_cnt_o, m_bcnt);
    chk("taken_cnt", taken_cnt_o, m_tcnt);
    m_res = xfer;
    m_pc  = taken;
    if (clear_cnt) begin
      m_bcnt = 0; m_tcnt = 0;
    end else begin
      if (xfer && (m_e.br || m_e.jp) && m_bcnt < CNT_MAX) m_bcnt++;
      if (taken && m_tcnt < CNT_MAX) m_tcnt++;
    end
    if (taken) m_sq = FLUSH_DEPTH;
    else if (hs && m_sq > 0) m_sq--;
    if (hs && !exp_flush) begin
      m_valid = 1;
      m_e.code = ref_code(alu_op, func3, func7_5, op5);
      m_e.ill  = (alu_op == 2'b11) || (branch && (func3 == 3'd2 || func3 == 3'd3));
      m_e.br   = branch;
      m_e.jp   = jump;
      m_e.f3   = func3;
    end else if (xfer) begin
      m_valid = 0;
    end
    @(negedge clk);
  endtask

  task automatic drive_rand();
    in_valid  = ($urandom_range(3) != 0);
    func3     = 3'($urandom_range(7));
    func7_5   = 1'($urandom_range(1));
    op5       = 1'($urandom_range(1));
    alu_op    = 2'($urandom_range(3));
    branch    = ($urandom_range(9) < 4);
    jump      = ($urandom_range(9) == 0);
    if (branch && jump && (func3 == 3'd2 || func3 == 3'd3)) branch = 1'b0;
    flag_zero = 1'($urandom_range(1));
    flag_lt   = 1'($urandom_range(1));
    flag_ltu  = 1'($urandom_range(1));
    ex_ready  = ($urandom_range(4) != 0);
    clear_cnt = ($urandom_range(31) == 0);
  endtask

  // plain ALU ops drain any pending squash, then idle cycles empty S1
  task automatic settle();
    ex_ready = 1; clear_cnt = 0;
    set_in(1, 3'd0, 0, 0, 2'b00, 0, 0);
    repeat (4) cycle();
    in_valid = 0;
    repeat (2) cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rtype_tab[0] = 4'h0; rtype_tab[1] = 4'h7; rtype_tab[2] = 4'h5; rtype_tab[3] = 4'h6;
    rtype_tab[4] = 4'h4; rtype_tab[5] = 4'h8; rtype_tab[6] = 4'h3; rtype_tab[7] = 4'h2;
    model_reset();

    #1;
    chk("rst_ctrl_valid", ctrl_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_alu_ctrl", alu_ctrl_o, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_flush", flush_o, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;

    // R-type sweep plus the non-R ALUOp codes
    ex_ready = 1;
    for (int i = 0; i < 32; i++) begin
      set_in(1, 3'(i >> 2), i[1], i[0], 2'b10, 0, 0);
      cycle();
    end
    set_in(1, 3'd0, 1, 1, 2'b10, 0, 0); cycle();
    chk("sub_rtype", alu_ctrl_o, 5'h01);
    set_in(1, 3'd0, 1, 0, 2'b10, 0, 0); cycle();
    chk("add_imm", alu_ctrl_o, 5'h00);
    set_in(1, 3'd5, 1, 0, 2'b10, 0, 0); cycle();
    chk("sra", alu_ctrl_o, 5'h09);
    set_in(1, 3'd2, 0, 0, 2'b11, 0, 0); cycle();
    chk("aluop11_code", alu_ctrl_o, 5'h0F);
    chk("aluop11_ill", illegal_o, 1);
    set_in(1, 3'd0, 0, 0, 2'b01, 0, 0); cycle();

    // branch truth table, each func3 with every flag combination
    settle();
    for (int f = 0; f < 8; f++) begin
      for (int fl = 0; fl < 8; fl++) begin
        set_in(1, 3'(f), 0, 0, 2'b01, 1, 0);
        cycle();
        flag_zero = fl[0]; flag_lt = fl[1]; flag_ltu = fl[2];
        in_valid = 0;
        repeat (2) cycle();
      end
    end
    settle();
    set_in(1, 3'd2, 0, 0, 2'b01, 1, 0); cycle();
    chk("br010_ill", illegal_o, 1);
    in_valid = 0; flag_zero = 1; cycle();
    chk("br010_pcsrc", pcsrc_o, 0);
    set_in(1, 3'd1, 0, 0, 2'b01, 1, 1); cycle();
    in_valid = 0; flag_zero = 1; cycle();
    chk("jump_prio_pcsrc", pcsrc_o, 1);

    // squash with FLUSH_DEPTH=1
    settle();
    flag_zero = 0;
    set_in(1, 3'd0, 0, 0, 2'b01, 1, 0); cycle();
    chk("sq_beq_loaded", ctrl_valid, 1);
    set_in(1, 3'd0, 0, 0, 2'b00, 0, 0); flag_zero = 1; cycle();
    chk("sq_flush_a", obs_flush, 1);
    chk("sq_a_dropped", ctrl_valid, 0);
    chk("sq_taken", pcsrc_o, 1);
    flag_zero = 0; cycle();
    chk("sq_flush_b", obs_flush, 1);
    chk("sq_b_dropped", ctrl_valid, 0);
    set_in(1, 3'd0, 0, 0, 2'b01, 0, 0); cycle();
    chk("sq_flush_c", obs_flush, 0);
    chk("sq_c_loaded", ctrl_valid, 1);
    chk("sq_c_code", alu_ctrl_o, 5'h01);

    // backpressure
    ex_ready = 0;
    set_in(1, 3'd0, 0, 0, 2'b00, 0, 0);
    repeat (3) begin
      cycle();
      chk("bp_in_ready", obs_ready, 0);
      chk("bp_hold", alu_ctrl_o, 5'h01);
      chk("bp_res_valid", res_valid, 0);
    end
    ex_ready = 1; in_valid = 0; cycle();
    chk("bp_release", res_valid, 1);
    cycle();
    chk("bp_single", res_valid, 0);

    // saturating counters and clear priority
    settle();
    clear_cnt = 1; cycle(); clear_cnt = 0;
    set_in(1, 3'd0, 0, 0, 2'b00, 0, 1);
    repeat (20) cycle();
    chk("cnt_sat_branch", branch_cnt_o, 3);
    chk("cnt_sat_taken", taken_cnt_o, 3);
    settle();
    set_in(1, 3'd0, 0, 0, 2'b00, 0, 1); cycle();
    in_valid = 0; clear_cnt = 1; cycle(); clear_cnt = 0;
    chk("clr_beats_taken", pcsrc_o, 1);
    chk("clr_branch", branch_cnt_o, 0);
    chk("clr_taken", taken_cnt_o, 0);

    // randomized run
    settle();
    repeat (1500) begin
      drive_rand();
      cycle();
    end

    // asynchronous reset in the middle of a squash window
    settle();
    flag_zero = 0;
    set_in(1, 3'd0, 0, 0, 2'b01, 1, 0); cycle();
    set_in(0, 3'd0, 0, 0, 2'b00, 0, 0); flag_zero = 1; cycle();
    chk("pre_rst_res", res_valid, 1);
    chk("pre_rst_flush", flush_o, 1);
    #2 rst_n = 0;
    #1;
    chk("arst_res_valid", res_valid, 0);
    chk("arst_pcsrc", pcsrc_o, 0);
    chk("arst_flush", flush_o, 0);
    chk("arst_ctrl_valid", ctrl_valid, 0);
    chk("arst_bcnt", branch_cnt_o, 0);
    chk("arst_in_ready", in_ready, 1);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    set_in(1, 3'd0, 0, 0, 2'b01, 0, 0); cycle();
    chk("post_rst_load", ctrl_valid, 1);
    chk("post_rst_code", alu_ctrl_o, 5'h01);
    in_valid = 0; cycle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
